// File: rtl/calc_pkg.sv
// Shared types and helpers for the push-button accumulator calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    ST_EDIT,
    ST_EXEC,
    ST_RESULT
  } state_t;

  function automatic int unsigned digits_for(input int unsigned width);
    return (width + 3) / 4;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> 2-FF synchroniser -> debounced level -> 1-cycle rising-edge pulse.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/accum_calc_unit.sv
// Push-button accumulator calculator: button conditioning, edit/exec FSM,
// wrap/saturate arithmetic with sticky overflow, multiplexed hex display.
module accum_calc_unit
  import calc_pkg::*;
#(
  parameter  int unsigned WIDTH           = 8,
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  parameter  int unsigned SCAN_DIV        = 1024,
  parameter  int unsigned SATURATE        = 0,
  localparam int unsigned DIGITS          = digits_for(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              add_sub_btn,
  input  logic              operand_btn,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic              clr_btn,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              op_sub,
  output logic              ovf,
  output logic              exec_done
);

  localparam int unsigned SW = idx_width(SCAN_DIV);
  localparam int unsigned IW = idx_width(DIGITS);
  localparam logic [SW-1:0] LAST_SCAN = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);

  logic clr_p, exec_p, as_p, inc_p, dec_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk(clk), .rst(rst), .btn(clr_btn), .pulse(clr_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exec (
    .clk(clk), .rst(rst), .btn(operand_btn), .pulse(exec_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_add_sub (
    .clk(clk), .rst(rst), .btn(add_sub_btn), .pulse(as_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .rst(rst), .btn(inc_btn), .pulse(inc_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
    .clk(clk), .rst(rst), .btn(dec_btn), .pulse(dec_p));

  state_t           state;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;
  logic             range_err;
  logic [WIDTH-1:0] operand_next;
  logic             edit_p;

  always_comb begin
    sum  = {1'b0, acc} + {1'b0, operand};
    diff = {1'b0, acc} - {1'b0, operand};
    if (op_sub) begin
      range_err = diff[WIDTH];
      result    = (range_err && SATURATE != 0) ? '0 : diff[WIDTH-1:0];
    end else begin
      range_err = sum[WIDTH];
      result    = (range_err && SATURATE != 0) ? '1 : sum[WIDTH-1:0];
    end
  end

  always_comb begin
    operand_next = operand;
    if (inc_p && !dec_p)
      operand_next = operand + 1'b1;
    else if (dec_p && !inc_p)
      operand_next = operand - 1'b1;
  end

  assign edit_p = inc_p | dec_p;

  // Priority clr > exec > add_sub > inc/dec; pulses arriving during EXEC are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EDIT;
      operand   <= '0;
      acc       <= '0;
      op_sub    <= 1'b0;
      ovf       <= 1'b0;
      exec_done <= 1'b0;
    end else begin
      exec_done <= 1'b0;
      if (clr_p) begin
        acc   <= '0;
        ovf   <= 1'b0;
        state <= ST_RESULT;
      end else begin
        case (state)
          ST_EDIT: begin
            if (exec_p) begin
              state     <= ST_EXEC;
              exec_done <= 1'b1;
            end else if (as_p) begin
              op_sub <= ~op_sub;
            end else if (edit_p) begin
              operand <= operand_next;
            end
          end
          ST_EXEC: begin
            acc   <= result;
            ovf   <= ovf | range_err;
            state <= ST_RESULT;
          end
          ST_RESULT: begin
            if (exec_p) begin
              state     <= ST_EXEC;
              exec_done <= 1'b1;
            end else if (as_p) begin
              op_sub <= ~op_sub;
            end else if (edit_p) begin
              operand <= operand_next;
              state   <= ST_EDIT;
            end
          end
          default: state <= ST_EDIT;
        endcase
      end
    end
  end

  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       scan_idx;
  logic [DIGITS*4-1:0] shown;
  logic [3:0]          nibble;
  logic [DIGITS-1:0]   an_next;

  always_comb begin
    shown            = '0;
    shown[WIDTH-1:0] = (state == ST_EDIT) ? operand : acc;
    nibble           = '0;
    an_next          = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (IW'(d) == scan_idx) begin
        nibble     = shown[d*4 +: 4];
        an_next[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg      <= '0;
      an       <= '0;
    end else begin
      if (scan_cnt == LAST_SCAN) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      seg <= hex_to_seg(nibble);
      an  <= an_next;
    end
  end

endmodule
